// File: rtl/lvds_tx_gear_n.sv
// Parallel-to-serial gearbox feeding external ODDR primitives: one word per lane every
// RATIO/2 clocks, two bits per lane per clock, with training-word substitution on underflow.
module lvds_tx_gear_n #(
  parameter int          LANES      = 4,
  parameter int          RATIO      = 10,
  parameter int          MSB_FIRST  = 1,
  parameter logic [15:0] TRAIN_WORD = 16'h03E0,
  parameter int          UF_CNT_W   = 16
) (
  input  logic                     I_serial_clk,
  input  logic                     I_rst_n,
  input  logic [LANES*RATIO-1:0]   I_data_in,
  input  logic                     I_data_valid,
  output logic                     O_data_ready,
  input  logic                     I_train_en,
  output logic [LANES-1:0]         O_ddr_d0,
  output logic [LANES-1:0]         O_ddr_d1,
  output logic                     O_word_strobe,
  output logic                     O_underflow,
  output logic [UF_CNT_W-1:0]      O_underflow_cnt
);

  localparam int K     = RATIO / 2;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam int W     = LANES * RATIO;
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(K - 1);
  localparam logic [RATIO-1:0] TRAIN_R   = TRAIN_WORD[RATIO-1:0];
  localparam logic [W-1:0]     TRAIN_ALL = {LANES{TRAIN_R}};

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [W-1:0]        buf_q, buf_d;
  logic                buf_full_q, buf_full_d;
  logic [W-1:0]        sreg_q, sreg_d;
  logic                loaded_q, loaded_d;
  logic                subst_q, subst_d;
  logic [LANES-1:0]    d0_q, d0_d, d1_q, d1_d;
  logic                strobe_q, strobe_d;
  logic                underflow_q, underflow_d;
  logic [UF_CNT_W-1:0] uf_cnt_q, uf_cnt_d;
  logic                load;
  logic                xfer;

  assign load         = (cnt_q == LAST);
  assign O_data_ready = !buf_full_q || (load && !I_train_en);
  assign xfer         = I_data_valid && O_data_ready;

  always_comb begin
    cnt_d       = load ? '0 : cnt_q + CNT_W'(1);
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    loaded_d    = loaded_q;
    subst_d     = subst_q;
    sreg_d      = sreg_q;
    d0_d        = '0;
    d1_d        = '0;

    for (int n = 0; n < LANES; n++) begin
      if (MSB_FIRST != 0) begin
        d0_d[n] = sreg_q[n*RATIO + RATIO - 1];
        d1_d[n] = sreg_q[n*RATIO + RATIO - 2];
        sreg_d[n*RATIO +: RATIO] = {sreg_q[n*RATIO +: RATIO-2], 2'b00};
      end else begin
        d0_d[n] = sreg_q[n*RATIO];
        d1_d[n] = sreg_q[n*RATIO + 1];
        sreg_d[n*RATIO +: RATIO] = {2'b00, sreg_q[n*RATIO + 2 +: RATIO-2]};
      end
    end

    // The pair presented on the edge after a load is the first one of that word.
    strobe_d    = loaded_q && (cnt_q == '0);
    underflow_d = strobe_d && subst_q;
    uf_cnt_d    = (underflow_d && (uf_cnt_q != '1)) ? uf_cnt_q + UF_CNT_W'(1) : uf_cnt_q;

    if (load) begin
      loaded_d = 1'b1;
      if (I_train_en) begin
        sreg_d  = TRAIN_ALL;
        subst_d = 1'b0;
      end else if (buf_full_q) begin
        sreg_d     = buf_q;
        buf_full_d = 1'b0;
        subst_d    = 1'b0;
      end else begin
        sreg_d  = TRAIN_ALL;
        subst_d = 1'b1;
      end
    end

    // A word arriving on a load edge into an empty buffer waits for the next boundary.
    if (xfer) begin
      buf_d      = I_data_in;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge I_serial_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      cnt_q       <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      sreg_q      <= '0;
      loaded_q    <= 1'b0;
      subst_q     <= 1'b0;
      d0_q        <= '0;
      d1_q        <= '0;
      strobe_q    <= 1'b0;
      underflow_q <= 1'b0;
      uf_cnt_q    <= '0;
    end else begin
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      sreg_q      <= sreg_d;
      loaded_q    <= loaded_d;
      subst_q     <= subst_d;
      d0_q        <= d0_d;
      d1_q        <= d1_d;
      strobe_q    <= strobe_d;
      underflow_q <= underflow_d;
      uf_cnt_q    <= uf_cnt_d;
    end
  end

  assign O_ddr_d0        = d0_q;
  assign O_ddr_d1        = d1_q;
  assign O_word_strobe   = strobe_q;
  assign O_underflow     = underflow_q;
  assign O_underflow_cnt = uf_cnt_q;

endmodule

// File: tb/tb_lvds_tx_gear_n.sv
// Bench for lvds_tx_gear_n: a word-level queue model checked every cycle against a
// 4-lane MSB-first instance, plus literal checks on a 1-lane LSB-first instance.
module tb_lvds_tx_gear_n;

  localparam int LANES = 4;
  localparam int RATIO = 10;
  localparam int K     = RATIO / 2;
  localparam int UFW   = 4;
  localparam int W     = LANES * RATIO;
  localparam int UF_MAX = (1 << UFW) - 1;
  localparam logic [RATIO-1:0] TRAIN     = 10'b1111100000;
  localparam logic [W-1:0]     TRAIN_ALL = {LANES{TRAIN}};

  typedef struct packed {
    logic [LANES-1:0] d0;
    logic [LANES-1:0] d1;
    logic             strobe;
    logic             uf;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [W-1:0]     data_in;
  logic             valid, train;
  logic             ready;
  logic [LANES-1:0] d0, d1;
  logic             strobe, uf;
  logic [UFW-1:0]   uf_cnt;

  logic [RATIO-1:0] lsb_data;
  logic             lsb_valid;
  logic             lsb_ready, lsb_d0, lsb_d1, lsb_strobe, lsb_uf;
  logic [15:0]      lsb_uf_cnt;

  lvds_tx_gear_n #(.LANES(LANES), .RATIO(RATIO), .MSB_FIRST(1), .TRAIN_WORD(16'h03E0),
                   .UF_CNT_W(UFW)) dut (
    .I_serial_clk(clk), .I_rst_n(rst_n), .I_data_in(data_in), .I_data_valid(valid),
    .O_data_ready(ready), .I_train_en(train), .O_ddr_d0(d0), .O_ddr_d1(d1),
    .O_word_strobe(strobe), .O_underflow(uf), .O_underflow_cnt(uf_cnt));

  lvds_tx_gear_n #(.LANES(1), .RATIO(RATIO), .MSB_FIRST(0), .TRAIN_WORD(16'h03E0),
                   .UF_CNT_W(16)) dut_lsb (
    .I_serial_clk(clk), .I_rst_n(rst_n), .I_data_in(lsb_data), .I_data_valid(lsb_valid),
    .O_data_ready(lsb_ready), .I_train_en(1'b0), .O_ddr_d0(lsb_d0), .O_ddr_d1(lsb_d1),
    .O_word_strobe(lsb_strobe), .O_underflow(lsb_uf), .O_underflow_cnt(lsb_uf_cnt));

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model state: phase within the word, one-entry buffer, and the queue of pairs still to appear.
  int         phase;
  logic       full_m;
  logic [W-1:0] buf_m;
  rec_t       cur_m;
  rec_t       exp_q[$];
  int         ucnt_m;

  initial begin
    phase = 0; full_m = 1'b0; buf_m = '0; cur_m = '0; ucnt_m = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        phase = 0; full_m = 1'b0; buf_m = '0; cur_m = '0; ucnt_m = 0;
        exp_q.delete();
      end else begin
        logic         take;
        logic [W-1:0] word;
        logic         subst;
        cur_m = (exp_q.size() > 0) ? exp_q.pop_front() : rec_t'(0);
        if (cur_m.uf && ucnt_m < UF_MAX) ucnt_m++;
        take = valid && (!full_m || (phase == K-1 && !train));
        if (phase == K-1) begin
          subst = 1'b0;
          if (train) word = TRAIN_ALL;
          else if (full_m) begin word = buf_m; full_m = 1'b0; end
          else begin word = TRAIN_ALL; subst = 1'b1; end
          for (int i = 0; i < K; i++) begin
            rec_t r;
            r.strobe = (i == 0);
            r.uf     = (i == 0) && subst;
            for (int n = 0; n < LANES; n++) begin
              r.d0[n] = word[n*RATIO + RATIO - 1 - 2*i];
              r.d1[n] = word[n*RATIO + RATIO - 2 - 2*i];
            end
            exp_q.push_back(r);
          end
        end
        if (take) begin buf_m = data_in; full_m = 1'b1; end
        phase = (phase + 1) % K;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      checkOutput("d0", 32'(d0), 32'(cur_m.d0));
      checkOutput("d1", 32'(d1), 32'(cur_m.d1));
      checkOutput("strobe", 32'(strobe), 32'(cur_m.strobe));
      checkOutput("underflow", 32'(uf), 32'(cur_m.uf));
      checkOutput("underflow_cnt", 32'(uf_cnt), 32'(ucnt_m));
      checkOutput("ready", 32'(ready), 32'(!full_m || (phase == K-1 && !train)));
    end
  end

  int uf_pulses;
  int strobes;
  initial begin
    uf_pulses = 0; strobes = 0;
    forever begin
      @(posedge clk);
      #1;
      if (uf) uf_pulses++;
      if (strobe) strobes++;
    end
  end

  int   data_base = 0;
  logic xfer_prev = 1'b0;

  function automatic logic [W-1:0] makeWord(input int base);
    logic [W-1:0] w;
    for (int n = 0; n < LANES; n++) w[n*RATIO +: RATIO] = RATIO'((base * LANES + n) % 256);
    return w;
  endfunction

  // Drives one cycle per iteration at the falling edge and returns just after the rising edge.
  task automatic applyStimulus(input int cycles, input logic v, input logic t,
                               input logic stop_on_strobe, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (xfer_prev) data_base++;
      valid = v; train = t; data_in = makeWord(data_base);
      #1;
      xfer_prev = valid && ready;
      @(posedge clk);
      #1;
      if (stop_on_strobe && strobe) begin seen = 1'b1; break; end
    end
  endtask

  logic [4:0] msb_d0_exp, msb_d1_exp, lsb_d0_exp, lsb_d1_exp;
  logic       seen;

  initial begin
    msb_d0_exp = 5'b00101; msb_d1_exp = 5'b11101;
    lsb_d0_exp = 5'b10111; lsb_d1_exp = 5'b10100;
    rst_n = 1'b0; valid = 1'b0; train = 1'b0; data_in = '0;
    lsb_valid = 1'b0; lsb_data = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_d0", 32'(d0), 32'h0);
    checkOutput("reset_d1", 32'(d1), 32'h0);
    checkOutput("reset_strobe", 32'(strobe), 32'h0);
    checkOutput("reset_underflow_cnt", 32'(uf_cnt), 32'h0);
    checkOutput("reset_ready", 32'(ready), 32'h1);

    // One known word on lane 0 of both instances, then idle.
    @(negedge clk);
    rst_n = 1'b1;
    valid = 1'b1; data_in = '0; data_in[RATIO-1:0] = 10'b1100110101;
    lsb_valid = 1'b1; lsb_data = 10'b1100110101;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0; lsb_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("no_strobe_at_first_load", 32'(strobe), 32'h0);
    for (int i = 0; i < K; i++) begin
      @(posedge clk);
      #1;
      checkOutput("msb_strobe", 32'(strobe), 32'(i == 0));
      checkOutput("msb_pair_d0", 32'(d0[0]), 32'(msb_d0_exp[i]));
      checkOutput("msb_pair_d1", 32'(d1[0]), 32'(msb_d1_exp[i]));
      checkOutput("lsb_strobe", 32'(lsb_strobe), 32'(i == 0));
      checkOutput("lsb_pair_d0", 32'(lsb_d0), 32'(lsb_d0_exp[i]));
      checkOutput("lsb_pair_d1", 32'(lsb_d1), 32'(lsb_d1_exp[i]));
    end

    // Continuous streaming: one word per K clocks and no underflow.
    applyStimulus(2, 1'b1, 1'b0, 1'b0, seen);
    uf_pulses = 0; strobes = 0;
    applyStimulus(60, 1'b1, 1'b0, 1'b0, seen);
    checkOutput("stream_no_underflow", 32'(uf_pulses), 32'h0);
    checkOutput("stream_strobe_count", 32'(strobes), 32'd12);

    // Training raised mid-word with a full buffer.
    applyStimulus(3*K, 1'b1, 1'b0, 1'b1, seen);
    checkOutput("strobe_found_before_train", 32'(seen), 32'h1);
    checkOutput("data_before_train_d0", 32'(d0), 32'h0);
    uf_pulses = 0;
    applyStimulus(1, 1'b1, 1'b1, 1'b0, seen);
    checkOutput("ready_during_train", 32'(ready), 32'h0);
    applyStimulus(3*K, 1'b1, 1'b1, 1'b1, seen);
    checkOutput("strobe_found_train", 32'(seen), 32'h1);
    checkOutput("train_word_d0", 32'(d0), 32'hF);
    checkOutput("train_word_d1", 32'(d1), 32'hF);
    applyStimulus(K, 1'b1, 1'b1, 1'b0, seen);
    applyStimulus(3*K, 1'b1, 1'b0, 1'b0, seen);
    checkOutput("train_no_underflow", 32'(uf_pulses), 32'h0);

    // Starvation: every word is the training word and the counter saturates.
    applyStimulus(20, 1'b0, 1'b0, 1'b0, seen);
    uf_pulses = 0;
    applyStimulus(100, 1'b0, 1'b0, 1'b0, seen);
    checkOutput("starve_underflow_pulses", 32'(uf_pulses), 32'd20);
    checkOutput("underflow_cnt_saturated", 32'(uf_cnt), 32'(UF_MAX));
    applyStimulus(3*K, 1'b0, 1'b0, 1'b1, seen);
    checkOutput("strobe_found_starve", 32'(seen), 32'h1);
    checkOutput("underflow_with_strobe", 32'(uf), 32'h1);
    checkOutput("starve_word_d0", 32'(d0), 32'hF);

    // Asynchronous reset in the middle of a word with the buffer full.
    applyStimulus(12, 1'b1, 1'b0, 1'b0, seen);
    applyStimulus(3*K, 1'b1, 1'b0, 1'b1, seen);
    checkOutput("strobe_found_before_reset", 32'(seen), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_d0", 32'(d0), 32'h0);
    checkOutput("async_reset_d1", 32'(d1), 32'h0);
    checkOutput("async_reset_strobe", 32'(strobe), 32'h0);
    checkOutput("async_reset_underflow", 32'(uf), 32'h0);
    checkOutput("async_reset_underflow_cnt", 32'(uf_cnt), 32'h0);
    checkOutput("async_reset_ready", 32'(ready), 32'h1);
    @(negedge clk);
    valid = 1'b0; xfer_prev = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (K) @(posedge clk);
    #1;
    checkOutput("post_reset_no_strobe_at_load", 32'(strobe), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("post_reset_first_strobe", 32'(strobe), 32'h1);
    checkOutput("post_reset_underflow", 32'(uf), 32'h1);
    checkOutput("post_reset_train_d0", 32'(d0), 32'hF);

    repeat (2) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
